// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the ALU issue stage.
//   - 4-bit ALU opcode encodings (AND, OR, ADD, SUB, SLT, NOR)
//   - RISC-V funct3 values the stage decodes
//   - decoded-entry struct {a, b, op, illegal} held in the skid buffer
//   - buffer occupancy states
// Entry operand fields are ALU_XLEN_MAX wide; modules with a narrower
// XLEN zero-extend into them and slice back out.
package alu_pkg;

    localparam int unsigned ALU_XLEN_MAX = 64;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_NOR = 4'b1100
    } alu_op_e;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLT    = 3'b010;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    typedef struct packed {
        logic [ALU_XLEN_MAX-1:0] a;
        logic [ALU_XLEN_MAX-1:0] b;
        alu_op_e                 op;
        logic                    illegal;
    } alu_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/alu_issue_decode.sv
// alu_issue_decode: combinational decode of funct3/funct7b5 into an ALU
// opcode plus operand selection.
// Ports:
//   funct3_i, funct7b5_i, is_imm_i  instruction fields
//   rs1_i, rs2_i, imm_i             XLEN-wide source operands
//   entry_o                         decoded entry; illegal entries carry
//                                   op=0000, a=b=0, illegal=1
module alu_issue_decode
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [2:0]      funct3_i,
    input  logic            funct7b5_i,
    input  logic            is_imm_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] imm_i,
    output alu_entry_t      entry_o
);

    always_comb begin
        entry_o         = '0;
        entry_o.op      = OP_AND;
        entry_o.illegal = 1'b0;
        unique case (funct3_i)
            // For the immediate form bit 30 belongs to the immediate, so
            // is_imm always yields ADD and SUB can never be paired with it.
            F3_ADDSUB: entry_o.op = (!is_imm_i && funct7b5_i) ? OP_SUB : OP_ADD;
            F3_AND:    entry_o.op = OP_AND;
            F3_OR:     entry_o.op = OP_OR;
            F3_SLT:    entry_o.op = OP_SLT;
            default:   entry_o.illegal = 1'b1;
        endcase

        if (entry_o.illegal) begin
            entry_o.op = OP_AND;
        end else begin
            entry_o.a = ALU_XLEN_MAX'(rs1_i);
            entry_o.b = ALU_XLEN_MAX'(is_imm_i ? imm_i : rs2_i);
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes an ALU instruction and holds it in a 2-entry
// buffer (EMPTY/ONE/FULL) feeding the ALU with valid/ready handshakes.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready, in_*          upstream instruction fields
//   out_valid/out_ready, out_*       head entry, driven straight from flops
//   illegal_cnt                      saturating count of accepted illegal
//                                    entries; only with ALU_ISSUE_ILLEGAL_CNT_EN
// in_ready is its own flop so out_ready has no combinational path to it,
// and so it stays low through reset and rises on the first edge after.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic             in_funct7b5,
    input  logic             in_is_imm,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_a,
    output logic [XLEN-1:0]  out_b,
    output logic [3:0]       out_op,
    output logic             out_illegal
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    ,
    output logic [CNT_W-1:0] illegal_cnt
`endif
);

    if (XLEN > ALU_XLEN_MAX || XLEN == 0 || CNT_W == 0) begin : g_cfg_err
        $error("alu_issue_stage: unsupported XLEN/CNT_W");
    end

    alu_entry_t dec_entry;
    alu_entry_t head_q, head_d;
    alu_entry_t tail_q, tail_d;
    buf_state_e state_q, state_d;
    logic       in_ready_q;
    logic       in_fire, out_fire;

    alu_issue_decode #(.XLEN(XLEN)) u_dec (
        .funct3_i   (in_funct3),
        .funct7b5_i (in_funct7b5),
        .is_imm_i   (in_is_imm),
        .rs1_i      (in_rs1),
        .rs2_i      (in_rs2),
        .imm_i      (in_imm),
        .entry_o    (dec_entry)
    );

    assign in_fire  = in_valid && in_ready_q;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    head_d  = dec_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    head_d = dec_entry;
                end else if (in_fire) begin
                    tail_d  = dec_entry;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so in_fire cannot occur.
                if (out_fire) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_a       = head_q.a[XLEN-1:0];
    assign out_b       = head_q.b[XLEN-1:0];
    assign out_op      = head_q.op;
    assign out_illegal = head_q.illegal;

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] illegal_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt_q <= '0;
        end else if (in_fire && dec_entry.illegal && (illegal_cnt_q != '1)) begin
            illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
        end
    end

    assign illegal_cnt = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned CNT_W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_funct3 = '0;
    logic            in_funct7b5 = 1'b0;
    logic            in_is_imm = 1'b0;
    logic [XLEN-1:0] in_rs1 = '0;
    logic [XLEN-1:0] in_rs2 = '0;
    logic [XLEN-1:0] in_imm = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [3:0]      out_op;
    logic            out_illegal;
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] illegal_cnt;
`endif

    alu_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct3   (in_funct3),
        .in_funct7b5 (in_funct7b5),
        .in_is_imm   (in_is_imm),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_op      (out_op),
        .out_illegal (out_illegal)
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
        ,
        .illegal_cnt (illegal_cnt)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        f7b5;
        logic        is_imm;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] imm;
        logic [3:0]  exp_op;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Sample point: 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f3, input logic f7, input logic im,
                         input logic [63:0] rs1, input logic [63:0] rs2, input logic [63:0] imm);
        in_valid    = 1'b1;
        in_funct3   = f3;
        in_funct7b5 = f7;
        in_is_imm   = im;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = imm;
    endtask

    initial begin
        vecs[0] = '{"addi",     3'b000, 1'b0, 1'b1, 64'd5,      64'h99,   64'hFFFF_FFFF_FFFF_FFFD, 4'b0010, 64'd5,      64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        vecs[1] = '{"sub",      3'b000, 1'b1, 1'b0, 64'd10,     64'd3,    64'h77,                  4'b0110, 64'd10,     64'd3,                   1'b0};
        vecs[2] = '{"add_rr",   3'b000, 1'b0, 1'b0, 64'd7,      64'd8,    64'h55,                  4'b0010, 64'd7,      64'd8,                   1'b0};
        vecs[3] = '{"and_rr",   3'b111, 1'b0, 1'b0, 64'hF0F0,   64'h0FF0, 64'h0,                   4'b0000, 64'hF0F0,   64'h0FF0,                1'b0};
        vecs[4] = '{"ori",      3'b110, 1'b0, 1'b1, 64'h100,    64'h2,    64'h0F,                  4'b0001, 64'h100,    64'h0F,                  1'b0};
        vecs[5] = '{"slt",      3'b010, 1'b0, 1'b0, '1,         64'd1,    64'h0,                   4'b0111, '1,         64'd1,                   1'b0};
        vecs[6] = '{"ill_001",  3'b001, 1'b0, 1'b0, 64'h1234,   64'h5678, 64'h0,                   4'b0000, 64'h0,      64'h0,                   1'b1};
        vecs[7] = '{"ill_101",  3'b101, 1'b1, 1'b1, 64'd9,      64'd9,    64'd9,                   4'b0000, 64'h0,      64'h0,                   1'b1};
        vecs[8] = '{"ill_100",  3'b100, 1'b0, 1'b0, 64'hAA,     64'hBB,   64'hCC,                  4'b0000, 64'h0,      64'h0,                   1'b1};
        vecs[9] = '{"slti",     3'b010, 1'b0, 1'b1, 64'd3,      64'd0,    64'd4,                   4'b0111, 64'd3,      64'd4,                   1'b0};

        // Reset state
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_a", out_a, 0);
        check("rst_out_b", out_b, 0);
        check("rst_out_op", out_op, 0);
        check("rst_out_illegal", out_illegal, 0);
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
        check("rst_illegal_cnt", illegal_cnt, 0);
`endif
        rst_n = 1'b1;
        #1;
        check("release_in_ready_low", in_ready, 0);
        tick();
        check("release_in_ready_rise", in_ready, 1);

        // Decode table, streamed back-to-back with out_ready=1
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].f3, vecs[i].f7b5, vecs[i].is_imm, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            tick();
            check({vecs[i].name, "_valid"}, out_valid, 1);
            check({vecs[i].name, "_op"}, out_op, vecs[i].exp_op);
            check({vecs[i].name, "_a"}, out_a, vecs[i].exp_a);
            check({vecs[i].name, "_b"}, out_b, vecs[i].exp_b);
            check({vecs[i].name, "_ill"}, out_illegal, vecs[i].exp_ill);
        end
        in_valid = 1'b0;
        tick();
        check("table_drain", out_valid, 0);
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
        check("table_illegal_cnt", illegal_cnt, 3);
`endif

        // Backpressure: A, B fill the buffer; C waits until space frees
        out_ready = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 64'd1, 64'd0, 64'd0);
        tick();
        check("bp_a_valid", out_valid, 1);
        drive(3'b000, 1'b0, 1'b0, 64'd2, 64'd0, 64'd0);
        tick();
        check("bp_full_in_ready", in_ready, 0);
        check("bp_head_a", out_a, 1);
        drive(3'b000, 1'b0, 1'b0, 64'd3, 64'd0, 64'd0);
        tick();
        check("bp_hold_in_ready", in_ready, 0);
        check("bp_hold_head_a", out_a, 1);
        check("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check("bp_head_b", out_a, 2);
        check("bp_in_ready_back", in_ready, 1);
        tick();
        check("bp_head_c", out_a, 3);
        in_valid = 1'b0;
        tick();
        check("bp_empty", out_valid, 0);

        // Simultaneous in/out in ONE for 10 cycles
        out_ready = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 64'd100, 64'd0, 64'd0);
        tick();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(3'b000, 1'b0, 1'b0, 64'(100 + i), 64'd0, 64'd0);
            tick();
            check($sformatf("sim_head_%0d", i), out_a, 64'(100 + i));
            check($sformatf("sim_ready_%0d", i), in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        check("sim_empty", out_valid, 0);

        // Reset while FULL
        out_ready = 1'b0;
        drive(3'b000, 1'b0, 1'b0, 64'd200, 64'd0, 64'd0);
        tick();
        drive(3'b000, 1'b0, 1'b0, 64'd201, 64'd0, 64'd0);
        tick();
        check("rfull_in_ready", in_ready, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rfull_out_valid", out_valid, 0);
        check("rfull_in_ready_rst", in_ready, 0);
        check("rfull_out_a", out_a, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rfull_no_stale_%0d", i), out_valid, 0);
        end
        check("rfull_in_ready_after", in_ready, 1);

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
        // Illegal counter: 0 -> 1, then saturation
        check("cnt_after_reset", illegal_cnt, 0);
        drive(3'b001, 1'b0, 1'b0, 64'd1, 64'd1, 64'd1);
        tick();
        check("cnt_one", illegal_cnt, 1);
        check("cnt_one_ill", out_illegal, 1);
        for (int i = 0; i < (1 << CNT_W) + 4; i++) begin
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("cnt_saturate", illegal_cnt, 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
